// File: rtl/snake_referee_if.sv
// Signal bundle between snake_pos/game control (master) and the snake_referee rule stage (slave).
interface snake_referee_if;
  localparam int unsigned CW = 5;
  localparam int unsigned BW = 4 * CW;
  localparam int unsigned SW = 8;
  localparam int unsigned LW = 3;

  logic          step;
  logic [CW-1:0] head_x;
  logic [CW-1:0] head_y;
  logic [BW-1:0] body_x;
  logic [BW-1:0] body_y;
  logic          grow;
  logic          die;
  logic [CW-1:0] food_x;
  logic [CW-1:0] food_y;
  logic [SW-1:0] score;
  logic [LW-1:0] length;
  logic          busy;

  modport master (
    output step, head_x, head_y, body_x, body_y,
    input  grow, die, food_x, food_y, score, length, busy
  );

  modport slave (
    input  step, head_x, head_y, body_x, body_y,
    output grow, die, food_x, food_y, score, length, busy
  );
endinterface

// File: rtl/snake_referee.sv
// Snake game rules: food placement via LFSR, food/wall/self-collision checks, score and length.
// Optional macro WALL_KILL_EN enables the out-of-bounds head kill rule.
module snake_referee #(
  parameter int unsigned MAX_X       = 23,
  parameter int unsigned MAX_Y       = 23,
  parameter int unsigned FOOD_INIT_X = 8,
  parameter int unsigned FOOD_INIT_Y = 8,
  parameter logic [9:0]  LFSR_SEED   = 10'h2A5,
  parameter int unsigned MAX_TRIES   = 31
) (
  input  logic            clk,
  input  logic            rst,
  snake_referee_if.slave  bus
);
  localparam int unsigned CW   = 5;
  localparam int unsigned LFW  = 10;
  localparam int unsigned SW   = 8;
  localparam int unsigned LW   = 3;
  localparam int unsigned NSEG = 4;
  localparam int unsigned TW   = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, CHECK, SPAWN, DEAD} state_t;

  state_t          state;
  logic [LFW-1:0]  lfsr;
  logic [TW-1:0]   tries;

  logic [LFW-1:0]  lfsr_next;
  logic [CW-1:0]   cand_x;
  logic [CW-1:0]   cand_y;
  logic            body_hit;
  logic            cand_body;
  logic            food_hit;
  logic            cand_ok;
  logic            kill;

  // Collision and candidate evaluation against the currently active segments
  always_comb begin
    lfsr_next = (lfsr == '0) ? LFSR_SEED : {lfsr[LFW-2:0], lfsr[9] ^ lfsr[6]};
    cand_x    = lfsr[4:0];
    cand_y    = lfsr[9:5];
    body_hit  = 1'b0;
    cand_body = 1'b0;
    for (int i = 0; i < int'(NSEG); i++) begin
      if (LW'(i + 1) < bus.length) begin
        if (bus.head_x == bus.body_x[CW*i +: CW] && bus.head_y == bus.body_y[CW*i +: CW])
          body_hit = 1'b1;
        if (cand_x == bus.body_x[CW*i +: CW] && cand_y == bus.body_y[CW*i +: CW])
          cand_body = 1'b1;
      end
    end
    food_hit = (bus.head_x == bus.food_x) && (bus.head_y == bus.food_y);
    cand_ok  = (cand_x <= CW'(MAX_X)) && (cand_y <= CW'(MAX_Y)) &&
               !((cand_x == bus.head_x) && (cand_y == bus.head_y)) &&
               !((cand_x == bus.food_x) && (cand_y == bus.food_y)) &&
               !cand_body;
`ifdef WALL_KILL_EN
    kill = body_hit || (bus.head_x > CW'(MAX_X)) || (bus.head_y > CW'(MAX_Y));
`else
    kill = body_hit;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      tries      <= '0;
      bus.grow   <= 1'b0;
      bus.die    <= 1'b0;
      bus.food_x <= CW'(FOOD_INIT_X);
      bus.food_y <= CW'(FOOD_INIT_Y);
      bus.score  <= '0;
      bus.length <= LW'(1);
      bus.busy   <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        IDLE: begin
          if (bus.step) begin
            state    <= CHECK;
            bus.busy <= 1'b1;
            // snake_pos consumes grow on this same edge
            if (bus.grow) begin
              bus.grow <= 1'b0;
              if (bus.length < LW'(5)) bus.length <= bus.length + LW'(1);
            end
          end
        end
        CHECK: begin
          if (kill) begin
            bus.die <= 1'b1;
            state   <= DEAD;
          end else if (food_hit) begin
            bus.grow <= 1'b1;
            if (bus.score != {SW{1'b1}}) bus.score <= bus.score + SW'(1);
            state <= SPAWN;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        SPAWN: begin
          if (cand_ok) begin
            bus.food_x <= cand_x;
            bus.food_y <= cand_y;
            tries      <= '0;
            state      <= IDLE;
            bus.busy   <= 1'b0;
          end else if (tries == TW'(MAX_TRIES - 1)) begin
            tries    <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            tries <= tries + TW'(1);
          end
        end
        DEAD: begin
          bus.die <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_snake_referee.sv
// Directed self-checking bench for snake_referee with an independent food-placement predictor.
module tb_snake_referee;
  localparam logic [9:0] SEED = 10'h2A5;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  snake_referee_if bus ();

  snake_referee dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] lfsr_adv(input logic [9:0] v);
    return (v == 10'd0) ? SEED : {v[8:0], v[9] ^ v[6]};
  endfunction

  // Reference LFSR: same reset and per-cycle advance as the referee's
  logic [9:0] m;
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= SEED;
    else      m <= lfsr_adv(m);
  end

  // Expected food {y,x} after a spawn that starts with LFSR value `start`
  function automatic logic [9:0] predict(input logic [9:0] start, input logic [4:0] hx,
                                         input logic [4:0] hy, input logic [19:0] bx,
                                         input logic [19:0] by, input int len,
                                         input logic [4:0] fx, input logic [4:0] fy);
    logic [9:0] v;
    logic [4:0] cx, cy;
    logic       ok;
    v = start;
    for (int t = 0; t < 31; t++) begin
      cx = v[4:0];
      cy = v[9:5];
      ok = (cx <= 5'd23) && (cy <= 5'd23) && !(cx == hx && cy == hy) && !(cx == fx && cy == fy);
      for (int s = 1; s <= 4; s++)
        if (s < len && cx == bx[5*(s-1) +: 5] && cy == by[5*(s-1) +: 5]) ok = 1'b0;
      if (ok) return {cy, cx};
      v = lfsr_adv(v);
    end
    return {fy, fx};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_step();
    @(negedge clk) bus.step = 1'b1;
    @(negedge clk) bus.step = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int c = 0; c < max_cycles && bus.busy !== 1'b0; c++) @(negedge clk);
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  logic [9:0] pred;
  logic [4:0] fx0, fy0;

  initial begin
    rst = 1'b0;
    bus.step = 1'b0;
    bus.head_x = '0; bus.head_y = '0;
    bus.body_x = '0; bus.body_y = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_grow",   32'(bus.grow),   32'd0);
    chk("rst_die",    32'(bus.die),    32'd0);
    chk("rst_food_x", 32'(bus.food_x), 32'd8);
    chk("rst_food_y", 32'(bus.food_y), 32'd8);
    chk("rst_score",  32'(bus.score),  32'd0);
    chk("rst_length", 32'(bus.length), 32'd1);
    chk("rst_busy",   32'(bus.busy),   32'd0);

    // Eat initial food
    bus.head_x = 5'd8; bus.head_y = 5'd8;
    pulse_step();
    @(negedge clk);
    chk("eat1_grow",  32'(bus.grow),  32'd1);
    chk("eat1_score", 32'(bus.score), 32'd1);
    chk("eat1_busy",  32'(bus.busy),  32'd1);
    pred = predict(m, 5'd8, 5'd8, bus.body_x, bus.body_y, 1, 5'd8, 5'd8);
    wait_idle(33);
    chk("eat1_food_x", 32'(bus.food_x), 32'(pred[4:0]));
    chk("eat1_food_y", 32'(bus.food_y), 32'(pred[9:5]));
    chk("eat1_food_in_range", 32'((bus.food_x <= 5'd23) && (bus.food_y <= 5'd23)), 32'd1);
    chk("eat1_food_moved", 32'((bus.food_x != 5'd8) || (bus.food_y != 5'd8)), 32'd1);

    // Miss step: grow consumed, length=2; inactive segment 2 sits on the head
    bus.head_x = bus.food_x ^ 5'd1; bus.head_y = bus.food_y;
    bus.body_x = {5'd0, 5'd0, bus.head_x, bus.head_x};
    bus.body_y = {5'd0, 5'd0, bus.head_y, bus.head_y ^ 5'd1};
    pulse_step();
    @(negedge clk);
    chk("miss_grow",   32'(bus.grow),   32'd0);
    chk("miss_length", 32'(bus.length), 32'd2);
    chk("miss_die",    32'(bus.die),    32'd0);
    chk("miss_busy",   32'(bus.busy),   32'd0);
    chk("miss_score",  32'(bus.score),  32'd1);

    // Second food at length 2
    bus.head_x = bus.food_x; bus.head_y = bus.food_y;
    bus.body_x = {15'd0, bus.food_x ^ 5'd1};
    bus.body_y = {15'd0, bus.food_y ^ 5'd1};
    fx0 = bus.food_x; fy0 = bus.food_y;
    pulse_step();
    @(negedge clk);
    chk("eat2_grow",  32'(bus.grow),  32'd1);
    chk("eat2_score", 32'(bus.score), 32'd2);
    pred = predict(m, fx0, fy0, bus.body_x, bus.body_y, 2, fx0, fy0);
    wait_idle(33);
    chk("eat2_food_x", 32'(bus.food_x), 32'(pred[4:0]));
    chk("eat2_food_y", 32'(bus.food_y), 32'(pred[9:5]));

    // Self-collision with body segment 1 at length 3
    bus.head_x = 5'd5; bus.head_y = 5'd5;
    bus.body_x = {15'd0, 5'd5};
    bus.body_y = {15'd0, 5'd5};
    pulse_step();
    @(negedge clk);
    chk("self_die",    32'(bus.die),    32'd1);
    chk("self_grow",   32'(bus.grow),   32'd0);
    chk("self_length", 32'(bus.length), 32'd3);
    chk("self_busy",   32'(bus.busy),   32'd1);
    fx0 = bus.food_x; fy0 = bus.food_y;
    pulse_step();
    @(negedge clk);
    pulse_step();
    repeat (3) @(negedge clk);
    chk("dead_die",    32'(bus.die),    32'd1);
    chk("dead_score",  32'(bus.score),  32'd2);
    chk("dead_food_x", 32'(bus.food_x), 32'(fx0));
    chk("dead_food_y", 32'(bus.food_y), 32'(fy0));
    chk("dead_length", 32'(bus.length), 32'd3);

    // Out-of-range head
    do_reset();
    bus.head_x = 5'd30; bus.head_y = 5'd2;
    bus.body_x = '0; bus.body_y = '0;
    pulse_step();
    @(negedge clk);
`ifdef WALL_KILL_EN
    chk("wall_die",  32'(bus.die),  32'd1);
    chk("wall_busy", 32'(bus.busy), 32'd1);
`else
    chk("wall_die",  32'(bus.die),  32'd0);
    chk("wall_busy", 32'(bus.busy), 32'd0);
`endif
    chk("wall_score", 32'(bus.score), 32'd0);

    // Asynchronous reset during SPAWN, checked before any clock edge
    do_reset();
    bus.head_x = 5'd8; bus.head_y = 5'd8;
    pulse_step();
    @(negedge clk);
    chk("pre_arst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_grow",   32'(bus.grow),   32'd0);
    chk("arst_score",  32'(bus.score),  32'd0);
    chk("arst_food_x", 32'(bus.food_x), 32'd8);
    chk("arst_food_y", 32'(bus.food_y), 32'd8);
    chk("arst_busy",   32'(bus.busy),   32'd0);
    chk("arst_length", 32'(bus.length), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    // Two steps one cycle apart: only the first is honoured
    pulse_step();
    @(negedge clk);
    pulse_step();
    wait_idle(40);
    chk("dbl_score", 32'(bus.score), 32'd1);
    chk("dbl_grow",  32'(bus.grow),  32'd1);
    chk("dbl_die",   32'(bus.die),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/snake_referee.md
Name: snake_referee

Overview:
- Game-rule stage directly downstream of snake_pos. Consumes the head and body coordinates it produces, and feeds back its grow and die inputs.
- Places food via an LFSR, detects food hits, wall hits and self-collision, and keeps score and snake length.
- One instance per game; driven by the same step strobe that drives snake_pos enable.

Parameters:
- MAX_X, 23, largest legal x coordinate (inclusive).
- MAX_Y, 23, largest legal y coordinate (inclusive).
- FOOD_INIT_X, 8, food x after reset.
- FOOD_INIT_Y, 8, food y after reset.
- LFSR_SEED, 10'h2A5, LFSR reset value; must be nonzero.
- MAX_TRIES, 31, SPAWN attempts before fallback.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- step  in  1  game tick strobe, one cycle wide; same signal as snake_pos enable.
- head_x  in  5  head x from snake_pos.
- head_y  in  5  head y from snake_pos.
- body_x  in  20  {x4,x3,x2,x1} body x from snake_pos.
- body_y  in  20  {y4,y3,y2,y1} body y from snake_pos.
- grow  out  1  level to snake_pos: grow on next step.
- die  out  1  level to snake_pos: sticky game-over.
- food_x  out  5  current food x.
- food_y  out  5  current food y.
- score  out  8  foods eaten, saturating.
- length  out  3  active segments including head, 1..5.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grow=0, die=0.
  - food=(FOOD_INIT_X,FOOD_INIT_Y), score=0, length=1.
  - lfsr=LFSR_SEED, try counter=0.
  - Reset mid-SPAWN or mid-CHECK discards all work in progress.
- LFSR:
  - 10-bit Fibonacci, taps x^10+x^7+1, shifts every cycle in every state.
  - If the register is ever 0, the next value is LFSR_SEED.
  - Candidate x=lfsr[4:0], y=lfsr[9:5].
- IDLE:
  - On step=1: go to CHECK.
  - If grow=1 on that same edge: clear grow and set length=min(length+1,5). snake_pos consumes grow on that edge.
  - step=1 in any other state is ignored; no queuing.
- CHECK (exactly 1 cycle; samples snake_pos outputs updated by the step edge). Priority, highest first:
  1. head_x>MAX_X or head_y>MAX_Y: die=1 -> DEAD (wall check subject to WALL_KILL_EN).
  2. Head equals body segment i for some i in 1..length-1: die=1 -> DEAD.
  3. Head equals food: grow=1, score=score+1 (saturating at 255) -> SPAWN.
  4. Otherwise -> IDLE.
  - Only segments below length are compared; masked-zero segments never collide.
- SPAWN (one candidate per cycle). A candidate is accepted when all of these hold:
  - x<=MAX_X and y<=MAX_Y.
  - It differs from the head and from every active body segment.
  - It differs from the current food position.
  - On accept: food=candidate, try counter=0 -> IDLE.
  - After MAX_TRIES rejections: food unchanged, try counter=0 -> IDLE (fallback).
- DEAD: terminal; die held at 1, all outputs frozen, step ignored; exits only via reset.
- Latency:
  - Step edge to die/grow valid: 2 cycles (CHECK result registered).
  - Step edge to new food valid: at most 2+MAX_TRIES cycles.
- Integration: step must be spaced at least MAX_TRIES+3 cycles apart to be honoured. Closer steps arriving while busy=1 are dropped.

Optional Feature:
- Macro: WALL_KILL_EN.
- Defined: the wall rule (CHECK priority 1) is active.
- Undefined: the wall rule is removed and out-of-range heads are legal. Only self-collision kills. Food candidates are still bounded by MAX_X/MAX_Y.

Test Plan:
- Reset, then hold rst=1 with no step -> grow=0, die=0, food=(8,8), score=0, length=1, busy=0.
- Drive head=(8,8) and step -> 2 cycles later grow=1, score=1. busy falls within 33 cycles; new food is in range and differs from (8,8) and the head. Next step clears grow and sets length=2.
- With length=3, drive head=(5,5), body_x1=(5), body_y1=(5), then step -> die=1, state DEAD. Further steps leave score and food unchanged.
- Drive head=(30,2) and step:
  - With WALL_KILL_EN: die=1.
  - Without it: die=0, busy=0 after the CHECK cycle.
- Pulse rst=0 during SPAWN -> all outputs return to reset values on that edge, with no clock required.
- Pulse step twice, 1 cycle apart -> second pulse ignored; only one CHECK occurs (score increments at most once).
